dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory (256 x 32, combinational read, synchronous write) between the pipeline MEM stage and a DMA/debug loader port. The MEM stage has fixed priority. A starvation counter forces one DMA grant, stalling the pipeline for that cycle, after the DMA port has waited `STARVE_LIMIT` consecutive cycles. The block sits between the MEM stage, the DMA engine and the data memory, and drives the memory's `Address`/`WriteData`/`MemWrite`/`MemRead` inputs.

## Interface
- `DATA_W`, 32, data width.
- `ADDR_W`, 32, address width. Passed through unchanged; the memory decodes `[7:0]`.
- `STARVE_LIMIT`, 4, consecutive lost DMA cycles before a forced DMA grant. Legal range ≥1.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_memread`  in  1  MEM-stage read request.
- `cpu_memwrite`  in  1  MEM-stage write request.
- `cpu_addr`  in  ADDR_W  MEM-stage address.
- `cpu_wdata`  in  DATA_W  MEM-stage write data.
- `cpu_rdata`  out  DATA_W  read data. Equals `mem_rdata` in a CPU-granted read cycle, else 0.
- `cpu_stall`  out  1  high when a CPU request is refused this cycle. Pipeline must hold MEM.
- `dma_valid`  in  1  DMA request. Held with its fields until accepted.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_addr`  in  ADDR_W  DMA address.
- `dma_wdata`  in  DATA_W  DMA write data.
- `dma_ready`  out  1  DMA request accepted this cycle (`dma_valid && dma_ready`).
- `dma_rvalid`  out  1  one-cycle pulse, DMA read data valid.
- `dma_rdata`  out  DATA_W  registered DMA read data.
- `mem_addr`  out  ADDR_W  to memory `Address`.
- `mem_wdata`  out  DATA_W  to memory `WriteData`.
- `mem_write`  out  1  to memory `MemWrite`.
- `mem_read`  out  1  to memory `MemRead`.
- `mem_rdata`  in  DATA_W  from memory `ReadData`.

## Operation
- `cpu_req` = `cpu_memread | cpu_memwrite`. If both are set, treat the request as a write and do not assert `mem_read`.
- States: NORMAL and FORCE. Counter `starve_cnt` has width clog2(STARVE_LIMIT+1).
- Grant decision is combinational and made every cycle:
  - FORCE && `dma_valid`: grant DMA. `cpu_stall` = `cpu_req`.
  - Otherwise `cpu_req`: grant CPU. `cpu_stall` = 0.
  - Otherwise `dma_valid`: grant DMA.
  - Otherwise: no grant.
- Memory mux:
  - CPU grant drives `mem_*` from the `cpu_*` fields.
  - DMA grant drives `mem_addr`/`mem_wdata` from the `dma_*` fields, with `mem_write` = `dma_we` and `mem_read` = `!dma_we`.
  - No grant drives all `mem_*` = 0.
- `dma_ready` = DMA granted.
- Counter and state update:
  - `dma_valid` && !DMA granted: `starve_cnt`+1. When the incremented value equals STARVE_LIMIT, next state = FORCE and the counter saturates.
  - DMA granted, or `dma_valid` low: `starve_cnt` → 0.
  - FORCE always returns to NORMAL after one cycle, whether or not the DMA was granted.
- An accepted DMA read registers `mem_rdata` into `dma_rdata` and pulses `dma_rvalid` for one cycle. `dma_rdata` holds its value until the next DMA read. A DMA write produces no `dma_rvalid`.

## Timing
- Reset values (asynchronous, while `rst_n`=0): state NORMAL, `starve_cnt`=0, `dma_rvalid`=0, `dma_rdata`=0.
- Combinational outputs follow the inputs during reset: grant logic runs, and FORCE is never active.
- Latency:
  - CPU read: 0 cycles (same-cycle `cpu_rdata`).
  - CPU or DMA write: lands at the next rising edge.
  - DMA read: `dma_rvalid` one cycle after the accept cycle.
- Forced grant: with STARVE_LIMIT=4, continuous `cpu_req` and `dma_valid` from cycle 0, the DMA loses cycles 0–3 and is granted in cycle 4 with `cpu_stall`=1. The CPU is granted again in cycle 5.
- Back-to-back DMA reads produce back-to-back `dma_rvalid` pulses.
- Reset asserted mid-FORCE clears the state immediately, and `dma_rvalid` drops asynchronously.
- STARVE_LIMIT=1: every contended cycle alternates CPU, DMA, CPU, DMA.

## Test plan
- CPU only:
  - `cpu_memwrite` addr 0x10, data 0xDEADBEEF.
  - Next cycle `cpu_memread` addr 0x10 → same-cycle `cpu_rdata`=0xDEADBEEF, `cpu_stall`=0, `dma_ready`=0.
- DMA only:
  - DMA write 0x20←0x12345678, then DMA read 0x20 → `dma_ready`=1 both cycles.
  - `dma_rvalid`=1 with `dma_rdata`=0x12345678 one cycle after the read.
- Contention, STARVE_LIMIT=4: continuous CPU reads plus a DMA read of 0x20 → `dma_ready` first high in cycle 4, `cpu_stall`=1 only in cycle 4, `dma_rvalid` in cycle 5.
- DMA withdrawal:
  - `dma_valid` high for 2 contended cycles, low for 1, then high again → counter restarts.
  - Forced grant occurs only after 4 further lost cycles.
- Reset mid-operation:
  - Assert `rst_n`=0 in the FORCE cycle → `dma_rvalid`=0 and `dma_rdata`=0 immediately.
  - After release, the first contended cycle grants the CPU.
- Idle → all `mem_*`=0, `cpu_stall`=0, `dma_ready`=0, `cpu_rdata`=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the pipeline
// MEM stage (fixed priority) and a DMA/debug loader port. A starvation
// counter forces one DMA grant after STARVE_LIMIT consecutive lost cycles.
module dmem_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_memread,
    input  logic              cpu_memwrite,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_valid,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;

    logic cpu_req;
    logic cpu_rd;
    logic grant_cpu;
    logic grant_dma;

    // Grant decision: a pending forced slot beats the CPU, otherwise the CPU wins.
    always_comb begin
        cpu_req   = cpu_memread | cpu_memwrite;
        cpu_rd    = cpu_memread & ~cpu_memwrite;
        grant_dma = dma_valid && ((state == FORCE) || !cpu_req);
        grant_cpu = cpu_req && !grant_dma;
    end

    // Memory-port mux and requester-facing handshake outputs.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (grant_cpu) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_write = cpu_memwrite;
            mem_read  = cpu_rd;
        end else if (grant_dma) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_write = dma_we;
            mem_read  = ~dma_we;
        end
        cpu_stall = cpu_req & ~grant_cpu;
        dma_ready = grant_dma;
        cpu_rdata = (grant_cpu && cpu_rd) ? mem_rdata : '0;
    end

    // Starvation tracking: FORCE lasts exactly one cycle, the counter saturates at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state <= NORMAL;
            if (dma_valid && !grant_dma) begin
                if (starve_cnt >= CNT_MAX - 1'b1) begin
                    starve_cnt <= CNT_MAX;
                    state      <= FORCE;
                end else begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // DMA read return: capture memory data on an accepted read, pulse valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= grant_dma & ~dma_we;
            if (grant_dma && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand-written corner sequences
// and a randomized run against a behavioural model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_memread, cpu_memwrite;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_valid, dma_we;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dma_ready, dma_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    // second instance with STARVE_LIMIT=1 sharing the same requests
    logic [31:0] u1_cpu_rdata, u1_dma_rdata, u1_mem_addr, u1_mem_wdata;
    logic        u1_cpu_stall, u1_dma_ready, u1_dma_rvalid, u1_mem_write, u1_mem_read;
    logic [31:0] u1_mem_rdata = 32'h0;

    logic [31:0] mem [256];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(LIM)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_valid(dma_valid), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(dma_ready), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(u1_cpu_rdata), .cpu_stall(u1_cpu_stall),
        .dma_valid(dma_valid), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ready(u1_dma_ready), .dma_rvalid(u1_dma_rvalid), .dma_rdata(u1_dma_rdata),
        .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
        .mem_write(u1_mem_write), .mem_read(u1_mem_read), .mem_rdata(u1_mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // data memory: combinational read, synchronous write
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    end

    // ---------------- behavioural reference model ----------------
    logic [31:0] ref_mem [256];
    int          streak, streak1;      // consecutive cycles the DMA request has lost
    logic        e_rv;
    logic [31:0] e_drd;
    logic        m_dg, m_cg, m_dg1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        streak  = 0;
        streak1 = 0;
        e_rv    = 1'b0;
        e_drd   = 32'h0;
    endtask

    task automatic model_check();
        logic        req, crd;
        logic [31:0] ea, ew;
        logic        ewr, erd;
        req   = cpu_memread | cpu_memwrite;
        crd   = cpu_memread & ~cpu_memwrite;
        m_dg  = dma_valid && (!req || streak == LIM);
        m_cg  = req && !m_dg;
        m_dg1 = dma_valid && (!req || streak1 == 1);
        ea = 32'h0; ew = 32'h0; ewr = 1'b0; erd = 1'b0;
        if (m_cg) begin
            ea = cpu_addr; ew = cpu_wdata; ewr = cpu_memwrite; erd = crd;
        end else if (m_dg) begin
            ea = dma_addr; ew = dma_wdata; ewr = dma_we; erd = !dma_we;
        end
        chk("mdl_mem_addr", mem_addr, ea);
        chk("mdl_mem_wdata", mem_wdata, ew);
        chk("mdl_mem_write", 32'(mem_write), 32'(ewr));
        chk("mdl_mem_read", 32'(mem_read), 32'(erd));
        chk("mdl_cpu_rdata", cpu_rdata, (m_cg && crd) ? ref_mem[cpu_addr[7:0]] : 32'h0);
        chk("mdl_cpu_stall", 32'(cpu_stall), 32'(req && !m_cg));
        chk("mdl_dma_ready", 32'(dma_ready), 32'(m_dg));
        chk("mdl_dma_rvalid", 32'(dma_rvalid), 32'(e_rv));
        chk("mdl_dma_rdata", dma_rdata, e_drd);
        chk("mdl_u1_dma_ready", 32'(u1_dma_ready), 32'(m_dg1));
        chk("mdl_u1_cpu_stall", 32'(u1_cpu_stall), 32'(req && m_dg1));
    endtask

    task automatic model_update();
        e_rv = m_dg && !dma_we;
        if (e_rv) e_drd = ref_mem[dma_addr[7:0]];
        if (m_cg && cpu_memwrite) ref_mem[cpu_addr[7:0]] = cpu_wdata;
        if (m_dg && dma_we)       ref_mem[dma_addr[7:0]] = dma_wdata;
        streak  = (dma_valid && !m_dg)  ? streak + 1  : 0;
        streak1 = (dma_valid && !m_dg1) ? streak1 + 1 : 0;
    endtask

    // inputs are set just after a falling edge; check, clock, advance model
    task automatic step();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic dv, input logic we, input logic [31:0] da, input logic [31:0] dd);
        cpu_memread = rd; cpu_memwrite = wr; cpu_addr = a; cpu_wdata = d;
        dma_valid = dv; dma_we = we; dma_addr = da; dma_wdata = dd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata;
        logic        dv, we;
        logic [31:0] daddr, ddata;
        logic        e_stall, e_ready;
        logic [31:0] e_crd;
        logic        e_rvalid;
        logic [31:0] e_drdata;
    } vec_t;

    vec_t tbl[21];

    function automatic vec_t mk(logic rd, logic wr, logic [31:0] a, logic [31:0] d,
                                logic dv, logic we, logic [31:0] da, logic [31:0] dd,
                                logic es, logic er, logic [31:0] ec, logic ev, logic [31:0] edr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
        v.dv = dv; v.we = we; v.daddr = da; v.ddata = dd;
        v.e_stall = es; v.e_ready = er; v.e_crd = ec; v.e_rvalid = ev; v.e_drdata = edr;
        return v;
    endfunction

    initial begin
        logic [31:0] tmp;
        logic        pend;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        model_reset();
        m_dg = 1'b0; m_cg = 1'b0; m_dg1 = 1'b0;

        //            rd wr addr   wdata        dv we daddr  ddata        stl rdy crd          rv rdata
        tbl[0]  = mk(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,  32'h0,        1, 1, 32'h20, 32'h12345678, 0, 1, 32'h0,        0, 32'h0);
        tbl[3]  = mk(0, 0, 32'h0,  32'h0,        1, 0, 32'h20, 32'h0,        0, 1, 32'h0,        0, 32'h0);
        tbl[4]  = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        1, 32'h12345678);
        for (int i = 5; i < 9; i++)
            tbl[i] = mk(1, 0, 32'h10, 32'h0,     1, 0, 32'h20, 32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h12345678);
        tbl[9]  = mk(1, 0, 32'h10, 32'h0,        1, 0, 32'h20, 32'h0,        1, 1, 32'h0,        0, 32'h12345678);
        tbl[10] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 1, 32'h12345678);
        tbl[11] = mk(0, 0, 32'h0,  32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'h0,        0, 32'h12345678);
        tbl[12] = mk(1, 0, 32'h10, 32'h0,        1, 1, 32'h30, 32'hA5A5A5A5, 0, 0, 32'hDEADBEEF, 0, 32'h12345678);
        tbl[13] = tbl[12];
        tbl[14] = mk(1, 0, 32'h10, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'hDEADBEEF, 0, 32'h12345678);
        for (int i = 15; i < 19; i++) tbl[i] = tbl[12];
        tbl[19] = mk(1, 0, 32'h10, 32'h0,        1, 1, 32'h30, 32'hA5A5A5A5, 1, 1, 32'h0,        0, 32'h12345678);
        tbl[20] = mk(1, 0, 32'h30, 32'h0,        0, 0, 32'h0,  32'h0,        0, 0, 32'hA5A5A5A5, 0, 32'h12345678);

        // reset: registered outputs cleared, grant logic live, no forced slot
        set_in(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        #2;
        chk("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("rst_dma_rdata", dma_rdata, 32'h0);
        chk("rst_dma_ready", 32'(dma_ready), 32'h0);
        chk("rst_mem_read", 32'(mem_read), 32'h1);
        model_check();
        @(negedge clk);
        set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_mem_addr", mem_addr, 32'h0);
        chk("idle_mem_ctl", {30'h0, mem_write, mem_read}, 32'h0);
        chk("idle_cpu_stall", 32'(cpu_stall), 32'h0);
        chk("idle_cpu_rdata", cpu_rdata, 32'h0);
        step();

        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata,
                   tbl[i].dv, tbl[i].we, tbl[i].daddr, tbl[i].ddata);
            #1;
            chk($sformatf("tbl%0d_cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_dma_ready", i), 32'(dma_ready), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
            chk($sformatf("tbl%0d_dma_rvalid", i), 32'(dma_rvalid), 32'(tbl[i].e_rvalid));
            chk($sformatf("tbl%0d_dma_rdata", i), dma_rdata, tbl[i].e_drdata);
            step();
        end

        // STARVE_LIMIT=1 instance alternates CPU/DMA under contention
        set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        step();
        for (int k = 0; k < 4; k++) begin
            set_in(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
            #1;
            chk($sformatf("alt%0d_u1_dma_ready", k), 32'(u1_dma_ready), 32'(k % 2));
            step();
        end

        // main instance is now in its forced cycle; reset lands in the middle of it
        set_in(1, 0, 32'h10, 32'h0, 1, 0, 32'h20, 32'h0);
        #1;
        chk("force_dma_ready", 32'(dma_ready), 32'h1);
        chk("force_cpu_stall", 32'(cpu_stall), 32'h1);
        chk("force_pre_rdata", dma_rdata, 32'h12345678);
        model_check();
        rst_n = 1'b0;
        #1;
        chk("rstmid_dma_rvalid", 32'(dma_rvalid), 32'h0);
        chk("rstmid_dma_rdata", dma_rdata, 32'h0);
        chk("rstmid_dma_ready", 32'(dma_ready), 32'h0);
        chk("rstmid_cpu_stall", 32'(cpu_stall), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("postrst_dma_ready", 32'(dma_ready), 32'h0);
        chk("postrst_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        step();

        // rvalid pulse from an accepted read drops asynchronously on reset
        set_in(0, 0, 32'h0, 32'h0, 1, 0, 32'h10, 32'h0);
        step();
        set_in(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
        #1;
        chk("pulse_dma_rvalid", 32'(dma_rvalid), 32'h1);
        chk("pulse_dma_rdata", dma_rdata, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("pulse_rst_rvalid", 32'(dma_rvalid), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic; DMA request fields held until accepted
        pend = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tmp = $urandom;
            cpu_memread  = ($urandom_range(0, 2) != 0);
            cpu_memwrite = ($urandom_range(0, 3) == 0);
            cpu_addr     = {tmp[31:8], 8'($urandom_range(0, 15))};
            cpu_wdata    = $urandom;
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend      = 1'b1;
                tmp       = $urandom;
                dma_we    = tmp[0];
                dma_addr  = {tmp[31:8], 8'($urandom_range(0, 15))};
                dma_wdata = $urandom;
            end
            dma_valid = pend;
            step();
            if (m_dg) pend = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
